// File: rtl/camera_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : camera_fb_arbiter                                            |
// | Description : Frame capture sequencer and single-port frame-buffer arbiter.|
// |               Camera pixel writes are queued in a small FIFO and share the |
// |               RAM port with CPU reads/writes; one RAM access per cycle.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset          system clock, asynchronous active-high reset         |
// |   cap_start           pulse: arm capture of the next frame                 |
// |   cap_continuous      re-arm automatically after each completed frame      |
// |   cap_busy            high while ARMED, CAPTURE or DRAIN                   |
// |   cap_done            1-cycle pulse when a frame is fully in RAM           |
// |   frame_cnt           completed-frame counter (wraps)                      |
// |   overflow / ovf_clr  sticky camera-drop flag and its clear                |
// |   cam_frame_start/end frame boundary pulses from the camera                |
// |   cam_valid/addr/data camera pixel write                                   |
// |   cpu_req/we/addr/wdata, cpu_ack/rdata   CPU access handshake             |
// |   mem_en/we/addr/wdata, mem_rdata        frame-buffer RAM port            |
// +----------------------------------------------------------------------------+
module camera_fb_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_CAM_RUN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_start,
    input  logic              cap_continuous,
    output logic              cap_busy,
    output logic              cap_done,
    output logic [7:0]        frame_cnt,
    output logic              overflow,
    input  logic              ovf_clr,
    input  logic              cam_frame_start,
    input  logic              cam_frame_end,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_RUN_W = $clog2(MAX_CAM_RUN + 1);

    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX   = c_RUN_W'(MAX_CAM_RUN);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ARMED   = 3'd1;
    localparam logic [2:0] c_CAPTURE = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic                w_cap_busy;
    logic                w_cap_done;
    logic                w_frame_done;

    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_RUN_W-1:0]  r_cam_run;
    logic                r_cpu_issue;     // CPU access on the RAM port this cycle
    logic                r_cpu_issue_rd;
    logic                r_cpu_ack;
    logic                r_cpu_ack_rd;
    logic                r_cam_mem;       // camera write on the RAM port this cycle
    logic [DATA_W-1:0]   r_rdata_hold;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [7:0]          r_frame_cnt;
    logic                r_overflow;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_cpu_busy;
    logic w_cpu_gnt;
    logic w_cam_gnt;
    logic w_push;
    logic w_drop;
    logic w_rd_ack;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FIFO_FULL);
    assign w_push_req = cam_valid && (r_state == c_CAPTURE);
    // The CPU stays locked out from its grant through its ack cycle, because
    // cpu_req is still high while the ack is being presented.
    assign w_cpu_busy = r_cpu_issue || r_cpu_ack;
    assign w_cpu_gnt  = cpu_req && !w_cpu_busy && (w_empty || (r_cam_run == c_RUN_MAX));
    assign w_cam_gnt  = !w_cpu_gnt && !w_empty;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_cam_gnt);
    assign w_drop     = w_push_req && w_full && !w_cam_gnt;
    assign w_rd_ack   = r_cpu_ack && r_cpu_ack_rd;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cap_busy   = 1'b0;
        w_cap_done   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (cap_start) w_next_state = c_ARMED;
            end
            c_ARMED: begin
                w_cap_busy = 1'b1;
                if (cam_frame_start) w_next_state = c_CAPTURE;
            end
            c_CAPTURE: begin
                w_cap_busy = 1'b1;
                if (cam_frame_end) w_next_state = c_DRAIN;
            end
            c_DRAIN: begin
                w_cap_busy = 1'b1;
                // Wait until the last popped pixel has actually hit the RAM port.
                if (w_empty && !r_cam_mem) begin
                    w_next_state = c_DONE;
                    w_frame_done = 1'b1;
                end
            end
            c_DONE: begin
                w_cap_done   = 1'b1;
                w_next_state = cap_continuous ? c_ARMED : c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Camera write FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cam_addr;
            r_fifo_data[r_wr_ptr] <= cam_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_cam_gnt) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_cam_gnt})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM port, CPU handshake, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cam_run      <= '0;
            r_cpu_issue    <= 1'b0;
            r_cpu_issue_rd <= 1'b0;
            r_cpu_ack      <= 1'b0;
            r_cpu_ack_rd   <= 1'b0;
            r_cam_mem      <= 1'b0;
            r_rdata_hold   <= '0;
            r_frame_cnt    <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_cpu_gnt) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= cpu_we;
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
            end else if (w_cam_gnt) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                r_mem_wdata <= r_fifo_data[r_rd_ptr];
            end else begin
                r_mem_en    <= 1'b0;
            end

            // Saturating run length of camera grants seen by a waiting CPU.
            if (!cpu_req || w_cpu_gnt) begin
                r_cam_run <= '0;
            end else if (w_cam_gnt && (r_cam_run != c_RUN_MAX)) begin
                r_cam_run <= r_cam_run + 1'b1;
            end

            r_cpu_issue    <= w_cpu_gnt;
            r_cpu_issue_rd <= w_cpu_gnt && !cpu_we;
            r_cpu_ack      <= r_cpu_issue;
            r_cpu_ack_rd   <= r_cpu_issue_rd;
            r_cam_mem      <= w_cam_gnt;

            if (w_rd_ack) r_rdata_hold <= mem_rdata;

            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign cap_busy  = w_cap_busy;
    assign cap_done  = w_cap_done;
    assign frame_cnt = r_frame_cnt;
    assign overflow  = r_overflow;
    assign cpu_ack   = r_cpu_ack;
    // Read data comes straight from the RAM in the ack cycle, then is held.
    assign cpu_rdata = w_rd_ack ? mem_rdata : r_rdata_hold;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
